// File: rtl/cpu_if.sv
// Observation bus of the single-cycle CPU: program counter, fetched instruction and ALU result.
interface cpu_if;
  logic [15:0] PC;
  logic [15:0] IR;
  logic [15:0] ALUOut;

  modport master (output PC, output IR, output ALUOut);
  modport slave  (input  PC, input  IR, input  ALUOut);
endinterface

// File: rtl/cpu.sv
// Single-cycle 16-bit CPU with a fixed instruction ROM and four-entry register file.
// Define CPU_HALT_EN to make 16'hFFFF a HALT that freezes the PC; otherwise it is reserved.
module cpu #(
  parameter int unsigned IMEM_DEPTH = 16
) (
  input logic   clock,
  input logic   resetn,
  cpu_if.master bus
);

  function automatic logic [15:0] rom_word(input logic [14:0] idx);
    logic [15:0] w;
    w = 16'hFFFF;
    if (32'(idx) < IMEM_DEPTH) begin
      case (idx)
        15'd0:   w = 16'h710F;
        15'd1:   w = 16'h7207;
        15'd2:   w = 16'h26C0;
        15'd3:   w = 16'h16C0;
        15'd4:   w = 16'h3980;
        15'd5:   w = 16'h06C0;
        15'd6:   w = 16'h4740;
        15'd7:   w = 16'h710F;
        15'd8:   w = 16'h65FF;
        default: w = 16'hFFFF;
      endcase
    end
    return w;
  endfunction

  logic [15:0] pc_q, pc_d;
  logic [15:0] rf_q [4];
  logic [15:0] rf_d [4];

  // A net so that an overriding drive on the fetch path falls back to the ROM cleanly.
  wire  [15:0] ir;
  assign ir = rom_word(pc_q[15:1]);

  logic [3:0]  op;
  logic [1:0]  rs, rt, rd;
  logic [15:0] imm, a, b;
  logic [15:0] alu;
  logic        we;
  logic [1:0]  wa;
  logic        is_halt;

  always_comb begin
    op  = ir[15:12];
    rs  = ir[11:10];
    rt  = ir[9:8];
    rd  = ir[7:6];
    imm = {{8{ir[7]}}, ir[7:0]};
    a   = (rs == 2'd0) ? 16'h0000 : rf_q[rs];
    b   = (rt == 2'd0) ? 16'h0000 : rf_q[rt];
  end

  always_comb begin
    alu = 16'h0000;
    we  = 1'b0;
    wa  = rd;
    case (op)
      4'h0: begin alu = a + b;         we = 1'b1; end
      4'h1: begin alu = a - b;         we = 1'b1; end
      4'h2: begin alu = a & b;         we = 1'b1; end
      4'h3: begin alu = a | b;         we = 1'b1; end
      4'h4: begin alu = ~(a | b);      we = 1'b1; end
      4'h6: begin
        alu = ($signed(a) < $signed(b)) ? 16'h0001 : 16'h0000;
        we  = 1'b1;
      end
      4'h7: begin alu = a + imm; we = 1'b1; wa = rt; end
      default: begin
        alu = 16'h0000;
        we  = 1'b0;
      end
    endcase
  end

  always_comb begin
`ifdef CPU_HALT_EN
    is_halt = (ir == 16'hFFFF);
`else
    is_halt = 1'b0;
`endif
  end

  always_comb begin
    pc_d = is_halt ? pc_q : pc_q + 16'd2;
    for (int i = 0; i < 4; i++) begin
      rf_d[i] = rf_q[i];
    end
    // $0 is hard-wired to zero, so writes aimed at it are simply dropped.
    if (we && (wa != 2'd0)) begin
      rf_d[wa] = alu;
    end
  end

  always_ff @(negedge clock or negedge resetn) begin
    if (!resetn) begin
      pc_q <= 16'h0000;
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= 16'h0000;
      end
    end else begin
      pc_q <= pc_d;
      for (int i = 0; i < 4; i++) begin
        rf_q[i] <= rf_d[i];
      end
    end
  end

  assign bus.PC     = pc_q;
  assign bus.IR     = ir;
  assign bus.ALUOut = alu;

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: reset, ROM program run, register file, arithmetic wrap, reserved ops.
module tb_cpu;

  logic clock = 1'b1;
  logic resetn;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  cpu_if bus ();

  cpu #(.IMEM_DEPTH(16)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  // Step to the middle of the high phase: state updated by the previous falling edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    #2;
    n_vec++;
    if (bus.PC !== 16'h0000) begin
      n_err++; $display("FAIL reset_pc: got %h expected %h", bus.PC, 16'h0000);
    end
    n_vec++;
    if (bus.IR !== 16'h710F) begin
      n_err++; $display("FAIL reset_ir: got %h expected %h", bus.IR, 16'h710F);
    end
    n_vec++;
    if (bus.ALUOut !== 16'd15) begin
      n_err++; $display("FAIL reset_alu: got %h expected %h", bus.ALUOut, 16'd15);
    end
    step();
    resetn = 1'b1;
  endtask

  task automatic test_program();
    logic [15:0] exp_alu [10];
    exp_alu = '{16'd15, 16'd7, 16'd7, 16'd8, 16'd15, 16'd30, 16'hFFE0, 16'd15, 16'd0, 16'd0};
    for (int i = 0; i < 10; i++) begin
      n_vec++;
      if (bus.PC !== 16'(2 * i)) begin
        n_err++; $display("FAIL prog_pc[%0d]: got %h expected %h", i, bus.PC, 16'(2 * i));
      end
      n_vec++;
      if (bus.ALUOut !== exp_alu[i]) begin
        n_err++; $display("FAIL prog_alu[%0d]: got %h expected %h", i, bus.ALUOut, exp_alu[i]);
      end
      step();
    end
`ifdef CPU_HALT_EN
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (bus.PC !== 16'd18 || bus.ALUOut !== 16'd0) begin
        n_err++; $display("FAIL halt_hold[%0d]: got pc %h alu %h expected pc %h alu %h",
                          i, bus.PC, bus.ALUOut, 16'd18, 16'd0);
      end
      step();
    end
`else
    n_vec++;
    if (bus.PC !== 16'd20 || bus.ALUOut !== 16'd0 || bus.IR !== 16'hFFFF) begin
      n_err++; $display("FAIL past_halt: got pc %h alu %h ir %h expected pc %h alu %h ir %h",
                        bus.PC, bus.ALUOut, bus.IR, 16'd20, 16'd0, 16'hFFFF);
    end
`endif
  endtask

  // Probes use ADD with rd=$0, so executing them changes nothing.
  task automatic test_reg_readback();
    force dut.ir = 16'h0400;
    #1;
    n_vec++;
    if (bus.ALUOut !== 16'd15) begin
      n_err++; $display("FAIL reg1: got %h expected %h", bus.ALUOut, 16'd15);
    end
    force dut.ir = 16'h0800;
    #1;
    n_vec++;
    if (bus.ALUOut !== 16'd15) begin
      n_err++; $display("FAIL reg2: got %h expected %h", bus.ALUOut, 16'd15);
    end
    force dut.ir = 16'h0C00;
    #1;
    n_vec++;
    if (bus.ALUOut !== 16'd0) begin
      n_err++; $display("FAIL reg3: got %h expected %h", bus.ALUOut, 16'd0);
    end
    force dut.ir = 16'h0000;
    step();
  endtask

  task automatic test_zero_reg();
    force dut.ir = 16'h0600;
    #1;
    n_vec++;
    if (bus.ALUOut !== 16'd30) begin
      n_err++; $display("FAIL add_to_r0: got %h expected %h", bus.ALUOut, 16'd30);
    end
    step();
    force dut.ir = 16'h0000;
    #1;
    n_vec++;
    if (bus.ALUOut !== 16'd0) begin
      n_err++; $display("FAIL r0_read: got %h expected %h", bus.ALUOut, 16'd0);
    end
    force dut.ir = 16'h0100;
    #1;
    n_vec++;
    if (bus.ALUOut !== 16'd15) begin
      n_err++; $display("FAIL r0_plus_r1: got %h expected %h", bus.ALUOut, 16'd15);
    end
    step();
  endtask

  task automatic test_wrap_arith();
    logic [15:0] exp_v;
    force dut.ir = 16'h7180;
    #1;
    n_vec++;
    if (bus.ALUOut !== 16'hFF80) begin
      n_err++; $display("FAIL addi_neg: got %h expected %h", bus.ALUOut, 16'hFF80);
    end
    step();
    // Double $1 eight times: -128 becomes 0x8000.
    force dut.ir = 16'h0540;
    exp_v = 16'hFF80;
    for (int k = 0; k < 8; k++) begin
      exp_v = exp_v << 1;
      #0;
      n_vec++;
      if (bus.ALUOut !== exp_v) begin
        n_err++; $display("FAIL double[%0d]: got %h expected %h", k, bus.ALUOut, exp_v);
      end
      step();
    end
    force dut.ir = 16'h7201;
    #1;
    n_vec++;
    if (bus.ALUOut !== 16'h0001) begin
      n_err++; $display("FAIL addi_one: got %h expected %h", bus.ALUOut, 16'h0001);
    end
    step();
    force dut.ir = 16'h16C0;
    #1;
    n_vec++;
    if (bus.ALUOut !== 16'h7FFF) begin
      n_err++; $display("FAIL sub_wrap: got %h expected %h", bus.ALUOut, 16'h7FFF);
    end
    force dut.ir = 16'h66C0;
    #1;
    n_vec++;
    if (bus.ALUOut !== 16'h0001) begin
      n_err++; $display("FAIL slt_neg: got %h expected %h", bus.ALUOut, 16'h0001);
    end
    force dut.ir = 16'h69C0;
    #1;
    n_vec++;
    if (bus.ALUOut !== 16'h0000) begin
      n_err++; $display("FAIL slt_pos: got %h expected %h", bus.ALUOut, 16'h0000);
    end
    force dut.ir = 16'h0000;
    step();
  endtask

  task automatic test_reserved();
    force dut.ir = 16'h5F40;
    #1;
    n_vec++;
    if (bus.ALUOut !== 16'h0000) begin
      n_err++; $display("FAIL rsv_op5: got %h expected %h", bus.ALUOut, 16'h0000);
    end
    step();
    force dut.ir = 16'h8540;
    #1;
    n_vec++;
    if (bus.ALUOut !== 16'h0000) begin
      n_err++; $display("FAIL rsv_op8: got %h expected %h", bus.ALUOut, 16'h0000);
    end
    step();
    force dut.ir = 16'h0400;
    #1;
    n_vec++;
    if (bus.ALUOut !== 16'h8000) begin
      n_err++; $display("FAIL rsv_nowrite: got %h expected %h", bus.ALUOut, 16'h8000);
    end
    release dut.ir;
    step();
  endtask

`ifndef CPU_HALT_EN
  task automatic test_pc_wrap();
    int cnt = 0;
    while (bus.PC !== 16'hFFFE && cnt < 40000) begin
      step();
      cnt++;
    end
    n_vec++;
    if (bus.PC !== 16'hFFFE) begin
      n_err++; $display("FAIL pc_reach_top: got %h expected %h", bus.PC, 16'hFFFE);
    end
    step();
    n_vec++;
    if (bus.PC !== 16'h0000) begin
      n_err++; $display("FAIL pc_wrap: got %h expected %h", bus.PC, 16'h0000);
    end
  endtask
`endif

  task automatic test_mid_reset();
    resetn = 1'b0;
    #1;
    n_vec++;
    if (bus.PC !== 16'h0000) begin
      n_err++; $display("FAIL rst_from_run: got %h expected %h", bus.PC, 16'h0000);
    end
    resetn = 1'b1;
    repeat (5) step();
    n_vec++;
    if (bus.PC !== 16'd10 || bus.ALUOut !== 16'd30) begin
      n_err++; $display("FAIL rerun_pc10: got pc %h alu %h expected pc %h alu %h",
                        bus.PC, bus.ALUOut, 16'd10, 16'd30);
    end
    resetn = 1'b0;
    #1;
    n_vec++;
    if (bus.PC !== 16'h0000 || bus.IR !== 16'h710F || bus.ALUOut !== 16'd15) begin
      n_err++; $display("FAIL mid_reset: got pc %h ir %h alu %h expected pc %h ir %h alu %h",
                        bus.PC, bus.IR, bus.ALUOut, 16'h0000, 16'h710F, 16'd15);
    end
    force dut.ir = 16'h0400;
    #1;
    n_vec++;
    if (bus.ALUOut !== 16'h0000) begin
      n_err++; $display("FAIL reset_regs: got %h expected %h", bus.ALUOut, 16'h0000);
    end
    release dut.ir;
    step();
    n_vec++;
    if (bus.PC !== 16'h0000) begin
      n_err++; $display("FAIL reset_hold: got %h expected %h", bus.PC, 16'h0000);
    end
    resetn = 1'b1;
    step();
    n_vec++;
    if (bus.PC !== 16'd2 || bus.ALUOut !== 16'd7) begin
      n_err++; $display("FAIL restart: got pc %h alu %h expected pc %h alu %h",
                        bus.PC, bus.ALUOut, 16'd2, 16'd7);
    end
  endtask

  initial begin
    test_reset();
    test_program();
    test_reg_readback();
    test_zero_reg();
    test_wrap_arith();
    test_reserved();
`ifndef CPU_HALT_EN
    test_pc_wrap();
`endif
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cpu.md
CPU -- requirements
Module: cpu

Interface
REQ-001 Parameter IMEM_DEPTH, default 16, number of 16-bit instruction ROM words.
REQ-002 clock  input  1  system clock; all state updates on its falling edge.
REQ-003 resetn  input  1  reset, asynchronous, active-low.
REQ-004 PC  output  16  current program counter, byte address, signed view.
REQ-005 IR  output  16  instruction at PC, combinational ROM read.
REQ-006 ALUOut  output  16  ALU result for IR, combinational, two's complement; equals register write data.

Function
REQ-007 Instruction formats:
- R-type: op[15:12], rs[11:10], rt[9:8], rd[7:6], [5:0] ignored.
- I-type: op, rs, rt, imm[7:0], imm sign-extended to 16 bits.
REQ-008 Opcodes:
- 0000 ADD rd=rs+rt
- 0001 SUB rd=rs-rt
- 0010 AND
- 0011 OR
- 0100 NOR
- 0110 SLT rd=(rs<rt, signed)?1:0
- 0111 ADDI rt=rs+sext(imm)
REQ-009 Opcodes 0101 and 1000-1111 other than IR=16'hFFFF are reserved: no register write, ALUOut=0, PC advances.
REQ-010 IR=16'hFFFF is HALT: ALUOut=0, no register write, PC holds indefinitely.
REQ-011 Register file: four 16-bit registers $0-$3, two combinational read ports, one write port on the falling edge; $0 always reads 0 and writes to it are discarded.
REQ-012 Arithmetic is 16-bit modulo 2^16; no overflow flag or trap.
REQ-013 Each non-HALT instruction completes in one clock cycle; PC<=PC+2 on each falling edge, wrapping at 16'hFFFE to 0.
REQ-014 ROM addressing and contents:
- ROM word index = PC[15:1].
- Indices >= IMEM_DEPTH read 16'hFFFF.
- Indices 0-9 hold 710F, 7207, 26C0, 16C0, 3980, 06C0, 4740, 710F, 65FF, FFFF (hex).
- Remaining entries are FFFF.

Reset
REQ-015 While resetn=0: PC=0 and all registers=0, immediately and independent of clock; IR and ALUOut reflect ROM word 0 against zeroed registers.
REQ-016 On resetn deassertion, the first update occurs on the next falling edge; a reset asserted mid-program, including while halted, restarts execution at PC 0.

Configuration
REQ-017 With macro CPU_HALT_EN defined, HALT behaves per REQ-010.
REQ-018 Without CPU_HALT_EN, 16'hFFFF is a reserved opcode per REQ-009: PC keeps advancing and wraps.

Verification
REQ-019 Reset then run the default ROM; per PC 0..18, ALUOut = 15, 7, 7, 8, 15, 30, -32, 15, 0, 0; PC stays 18 thereafter (CPU_HALT_EN).
REQ-020 Register check after the run: $1=15, $2=15, $3=0.
REQ-021 Register $0: ADD with rd=$0 then read $0 -> 0.
REQ-022 ADDI $1,$0,-128 (imm 0x80) -> ALUOut=-128; SUB of 0x8000 minus 1 -> 0x7FFF (wrap).
REQ-023 Assert resetn low between clock edges at PC=10 -> PC=0 at once, IR=710F, ALUOut=15.
REQ-024 Without CPU_HALT_EN, execute past PC 18 -> PC reaches 20, ALUOut=0, no register changes.
